// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow flag output enabled by macro SERIAL_SUB_SIGNED_OVF_EN.
module serial_ripple_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned RES_W = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic ai, bi, d_bit, br_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d       = ovf_q;
`endif

        ai     = a_q[0];
        bi     = b_q[0];
        d_bit  = ai ^ bi ^ br_q;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    br_d       = bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Result shifts right; the newest bit enters at the top
                res_d = RES_W'({d_bit, res_q} >> 1);
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nxt;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d      = {d_bit, res_q};
                    bout_d      = br_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // Last bit pair is the operand sign bits
                    ovf_d       = (ai ^ bi) & (d_bit ^ ai);
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4): directed table plus
// handshake, backpressure, reset-abort and back-to-back sequences.
module tb_serial_ripple_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
        logic         eovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, checking in_ready stays low; returns cycles waited
    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk({nm, " in_ready low while busy"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        if (!out_valid) chk({nm, " timeout out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Full operation with out_ready high; starts and ends in IDLE
    task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic binv, input logic [W-1:0] ed, input logic eb,
                          input logic eovf);
        int lat;
        chk({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = av; b = bv; bin = binv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(nm, lat);
        chk({nm, " latency"}, 32'(lat), 32'(W));
        chk({nm, " diff"}, 32'(diff), 32'(ed));
        chk({nm, " bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) chk({nm, " eovf defined"}, 32'(eovf), 32'd0);
`endif
        tick();
        chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int t_prev;
        logic [W:0] ref_r;

        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'd5,  4'd5,  1'b0, 4'h0, 1'b0, 1'b0};
        vecs[4] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[6] = '{4'd12, 4'd5,  1'b1, 4'h6, 1'b0, 1'b1};
        vecs[7] = '{4'd7,  4'd8,  1'b0, 4'hF, 1'b1, 1'b1};
        vecs[8] = '{4'd2,  4'd1,  1'b0, 4'h1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].ed, vecs[i].eb, vecs[i].eovf);

        // Backpressure: result held while out_ready low, in_valid ignored
        out_ready = 1'b0;
        a = 4'd12; b = 4'd5; bin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done("bp", lat);
        chk("bp latency", 32'(lat), 32'(W));
        for (int k = 0; k < 5; k++) begin
            a = 4'd1; b = 4'd2; bin = 1'b0; in_valid = (k % 2 == 0);
            tick();
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp diff held", 32'(diff), 32'h6);
            chk("bp bout held", 32'(bout), 32'd0);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp handshake out_valid", 32'(out_valid), 32'd0);
        chk("bp handshake in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp no stray accept", 32'(in_ready), 32'd1);
        chk("bp diff kept in idle", 32'(diff), 32'h6);

        // Reset two cycles into RUN
        a = 4'd15; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid diff stable in run", 32'(diff), 32'h6);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort diff", 32'(diff), 32'd0);
        chk("abort bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("after_abort", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);

        // Back-to-back with in_valid held high
        t_prev = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            int           guard;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            a = ra; b = rb; bin = rbin; in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 10) begin
                tick();
                guard++;
            end
            if (!in_ready) chk("b2b timeout in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            if (i > 0) chk("b2b accept spacing", 32'(cyc - t_prev), 32'(W + 2));
            t_prev = cyc;
            #1;
            ref_r = {1'b0, ra} - {1'b0, rb} - (W + 1)'(rbin);
            wait_done("b2b", lat);
            chk("b2b latency", 32'(lat), 32'(W));
            chk($sformatf("b2b%0d diff", i), 32'(diff), 32'(ref_r[W-1:0]));
            chk($sformatf("b2b%0d bout", i), 32'(bout), 32'(ref_r[W]));
        end
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
